// File: rtl/button_debounce.sv
// Active-low key synchronizer and bounce filter producing a clean active-high level.
// Define BUTTON_DEBOUNCE_BYPASS_EN to drop the filter and pass the synchronized key straight through.
module button_debounce #(
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH     = 20
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic KeyN,
  output logic Level,
  output logic Busy
);

  logic s1;
  logic s2;

  // Two-flop synchronizer; inversion makes "pressed" active-high from here on
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= ~KeyN;
      s2 <= s1;
    end
  end

`ifdef BUTTON_DEBOUNCE_BYPASS_EN

  assign Level = s2;
  assign Busy  = 1'b0;

`else

  typedef enum logic [1:0] {
    REL    = 2'd0,
    WAIT_P = 2'd1,
    PRS    = 2'd2,
    WAIT_R = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 level_q;
  logic                 busy_q;
  logic                 level_nxt;
  logic                 busy_nxt;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state   <= REL;
      cnt     <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      level_q <= level_nxt;
      busy_q  <= busy_nxt;
    end
  end

  // Any sample of the old value drops back to the settled state, so the run restarts
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      REL: begin
        if (s2) begin
          state_nxt = WAIT_P;
          cnt_nxt   = CNT_WIDTH'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      WAIT_P: begin
        if (!s2) begin
          state_nxt = REL;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRS;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      PRS: begin
        if (!s2) begin
          state_nxt = WAIT_R;
          cnt_nxt   = CNT_WIDTH'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      WAIT_R: begin
        if (s2) begin
          state_nxt = PRS;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = REL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = REL;
        cnt_nxt   = '0;
      end
    endcase
    level_nxt = (state_nxt == PRS) || (state_nxt == WAIT_R);
    busy_nxt  = (state_nxt == WAIT_P) || (state_nxt == WAIT_R);
  end

  assign Level = level_q;
  assign Busy  = busy_q;

`endif

endmodule
